// File: rtl/axi4lite_arbiter_if.sv
// AXI4-Lite master-side bundle used by the two-port arbiter.
// Only the channels the arbiter needs: AW, W, B, AR, R.
interface axi4lite_arbiter_if;
   logic [5:0]  awaddr;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic        rvalid;
   logic        rready;

   modport master (
      output awaddr, awvalid, wdata, wvalid, bready,
      output araddr, arvalid, rready,
      input  awready, wready, bresp, bvalid,
      input  arready, rdata, rvalid
   );

   modport slave (
      input  awaddr, awvalid, wdata, wvalid, bready,
      input  araddr, arvalid, rready,
      output awready, wready, bresp, bvalid,
      output arready, rdata, rvalid
   );
endinterface

// File: rtl/axi4lite_arbiter.sv
// Two-port round-robin arbiter feeding one AXI4-Lite master.
// One transaction in flight at a time; every output is registered.
module axi4lite_arbiter (
   input  logic               s_axi_aclk,
   input  logic               s_axi_aresetn,
   input  logic [1:0]         req_valid,
   input  logic [1:0]         req_we,
   input  logic [11:0]        req_addr,
   input  logic [63:0]        req_wdata,
   output logic [1:0]         req_done,
   output logic [31:0]        req_rdata,
   output logic [1:0]         req_resp,
   axi4lite_arbiter_if.master m_axi
);

   typedef enum logic [2:0] {
      IDLE,
      WADDR,
      WRESP,
      RADDR,
      RDATA,
      DONE
   } state_t;

   state_t      state;
   logic        last_grant;
   logic        grant;
   logic        aw_done;
   logic        w_done;

   logic        pick;
   logic        pick_we;
   logic [5:0]  pick_addr;
   logic [31:0] pick_wdata;

   logic        aw_hs;
   logic        w_hs;
   logic        b_hs;
   logic        ar_hs;
   logic        r_hs;
   logic        aw_ok;
   logic        w_ok;

   // Contention goes to whoever was not served last.
   always_comb begin
      pick = 1'b0;
      unique case (1'b1)
         (req_valid == 2'b11): pick = ~last_grant;
         (req_valid == 2'b10): pick = 1'b1;
         default:              pick = 1'b0;
      endcase
   end

   assign pick_we    = req_we[pick];
   assign pick_addr  = pick ? req_addr[11:6]
                          : req_addr[5:0];
   assign pick_wdata = pick ? req_wdata[63:32]
                          : req_wdata[31:0];

   assign aw_hs = m_axi.awvalid & m_axi.awready;
   assign w_hs  = m_axi.wvalid  & m_axi.wready;
   assign b_hs  = m_axi.bvalid  & m_axi.bready;
   assign ar_hs = m_axi.arvalid & m_axi.arready;
   assign r_hs  = m_axi.rvalid  & m_axi.rready;

   // AW and W finish independently; either may land first.
   assign aw_ok = aw_done | aw_hs;
   assign w_ok  = w_done  | w_hs;

   always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
      if (!s_axi_aresetn) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         grant         <= 1'b0;
         aw_done       <= 1'b0;
         w_done        <= 1'b0;
         m_axi.awaddr  <= '0;
         m_axi.awvalid <= 1'b0;
         m_axi.wdata   <= '0;
         m_axi.wvalid  <= 1'b0;
         m_axi.bready  <= 1'b0;
         m_axi.araddr  <= '0;
         m_axi.arvalid <= 1'b0;
         m_axi.rready  <= 1'b0;
         req_done      <= '0;
         req_rdata     <= '0;
         req_resp      <= '0;
      end else begin
         req_done <= '0;
         unique case (state)
            IDLE: begin
               if (|req_valid) begin
                  grant      <= pick;
                  last_grant <= pick;
                  aw_done    <= 1'b0;
                  w_done     <= 1'b0;
                  if (pick_we) begin
                     m_axi.awaddr  <= pick_addr;
                     m_axi.wdata   <= pick_wdata;
                     m_axi.awvalid <= 1'b1;
                     m_axi.wvalid  <= 1'b1;
                     state         <= WADDR;
                  end else begin
                     m_axi.araddr  <= pick_addr;
                     m_axi.arvalid <= 1'b1;
                     state         <= RADDR;
                  end
               end
            end
            WADDR: begin
               if (aw_hs) begin
                  m_axi.awvalid <= 1'b0;
                  aw_done       <= 1'b1;
               end
               if (w_hs) begin
                  m_axi.wvalid <= 1'b0;
                  w_done       <= 1'b1;
               end
               if (aw_ok && w_ok) begin
                  m_axi.bready <= 1'b1;
                  state        <= WRESP;
               end
            end
            WRESP: begin
               if (b_hs) begin
                  m_axi.bready <= 1'b0;
                  req_resp     <= m_axi.bresp;
                  req_done     <= grant ? 2'b10 : 2'b01;
                  state        <= DONE;
               end
            end
            RADDR: begin
               if (ar_hs) begin
                  m_axi.arvalid <= 1'b0;
                  m_axi.rready  <= 1'b1;
                  state         <= RDATA;
               end
            end
            RDATA: begin
               if (r_hs) begin
                  m_axi.rready <= 1'b0;
                  req_rdata    <= m_axi.rdata;
                  req_resp     <= 2'b00;
                  req_done     <= grant ? 2'b10 : 2'b01;
                  state        <= DONE;
               end
            end
            DONE: begin
               // Requests are not looked at here; IDLE picks next cycle.
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_axi4lite_arbiter.sv
// Randomised bench for axi4lite_arbiter with a memory-backed slave
// and a transaction-level model of grants, memory and responses.
module tb_axi4lite_arbiter;

   logic        clk;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_we;
   logic [11:0] req_addr;
   logic [63:0] req_wdata;
   logic [1:0]  req_done;
   logic [31:0] req_rdata;
   logic [1:0]  req_resp;

   axi4lite_arbiter_if bus ();

   axi4lite_arbiter dut (
      .s_axi_aclk    (clk),
      .s_axi_aresetn (rst_n),
      .req_valid     (req_valid),
      .req_we        (req_we),
      .req_addr      (req_addr),
      .req_wdata     (req_wdata),
      .req_done      (req_done),
      .req_rdata     (req_rdata),
      .req_resp      (req_resp),
      .m_axi         (bus.master)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks;
   int n_fail;

   // model state
   logic [31:0] ref_mem [64];
   int          model_last;
   logic [31:0] last_rd;

   // pending requester transactions
   logic [1:0]  p_valid;
   logic        p_we   [2];
   logic [5:0]  p_addr [2];
   logic [31:0] p_data [2];

   // slave configuration
   int aw_lat, w_lat, b_lat, ar_lat, r_lat;
   bit sl_rand;
   logic [31:0] sl_mem [64];

   // per-transaction observations
   int          aw_cyc, w_cyc, aw_rises, w_rises;
   logic [5:0]  aw_seen, ar_seen;
   logic [31:0] w_seen;
   bit          w_first, bad_order, overlap;

   initial begin : slave
      int aw_wait, w_wait, b_wait, ar_wait, r_wait;
      bit aw_got, w_got, b_fire, ar_got, r_fire;
      logic [5:0]  aw_a, ar_a;
      logic [31:0] w_d;
      for (int i = 0; i < 64; i++) sl_mem[i] = '0;
      aw_wait = 0; w_wait = 0; b_wait = 0;
      ar_wait = 0; r_wait = 0;
      aw_got = 0; w_got = 0; b_fire = 0;
      ar_got = 0; r_fire = 0;
      aw_a = '0; ar_a = '0; w_d = '0;
      bus.awready = 0; bus.wready = 0;
      bus.bvalid = 0; bus.bresp = '0;
      bus.arready = 0; bus.rvalid = 0;
      bus.rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            aw_wait = 0; w_wait = 0; b_wait = 0;
            ar_wait = 0; r_wait = 0;
            aw_got = 0; w_got = 0; b_fire = 0;
            ar_got = 0; r_fire = 0;
            bus.awready = 0; bus.wready = 0;
            bus.bvalid = 0; bus.arready = 0;
            bus.rvalid = 0;
         end else begin
            // B
            if (bus.bvalid) begin
               if (b_fire) begin
                  bus.bvalid = 0; b_fire = 0;
                  aw_got = 0; w_got = 0;
                  aw_wait = 0; w_wait = 0; b_wait = 0;
                  if (sl_rand) begin
                     aw_lat = $urandom_range(0, 4);
                     w_lat  = $urandom_range(0, 4);
                     b_lat  = $urandom_range(0, 3);
                  end
               end else if (bus.bready) b_fire = 1;
            end else if (aw_got && w_got) begin
               if (b_wait >= b_lat) begin
                  sl_mem[aw_a] = w_d;
                  bus.bresp  = aw_a[5:4];
                  bus.bvalid = 1;
                  if (bus.bready) b_fire = 1;
               end
               b_wait++;
            end
            // AW
            if (bus.awvalid && !aw_got) begin
               bus.awready = (aw_wait >= aw_lat);
               if (bus.awready) begin
                  aw_got = 1; aw_a = bus.awaddr;
               end
               aw_wait++;
            end else bus.awready = 0;
            // W
            if (bus.wvalid && !w_got) begin
               bus.wready = (w_wait >= w_lat);
               if (bus.wready) begin
                  w_got = 1; w_d = bus.wdata;
               end
               w_wait++;
            end else bus.wready = 0;
            // R
            if (bus.rvalid) begin
               if (r_fire) begin
                  bus.rvalid = 0; r_fire = 0;
                  ar_got = 0; ar_wait = 0; r_wait = 0;
                  if (sl_rand) begin
                     ar_lat = $urandom_range(0, 4);
                     r_lat  = $urandom_range(0, 3);
                  end
               end else if (bus.rready) r_fire = 1;
            end else if (ar_got) begin
               if (r_wait >= r_lat) begin
                  bus.rdata  = sl_mem[ar_a];
                  bus.rvalid = 1;
                  if (bus.rready) r_fire = 1;
               end
               r_wait++;
            end
            // AR
            if (bus.arvalid && !ar_got) begin
               bus.arready = (ar_wait >= ar_lat);
               if (bus.arready) begin
                  ar_got = 1; ar_a = bus.araddr;
               end
               ar_wait++;
            end else bus.arready = 0;
         end
      end
   end

   task automatic apply_req();
      req_valid = p_valid;
      req_we    = {p_we[1], p_we[0]};
      req_addr  = {p_addr[1], p_addr[0]};
      req_wdata = {p_data[1], p_data[0]};
   endtask

   task automatic new_txn(input int p);
      p_we[p]   = 1'($urandom_range(0, 1));
      p_addr[p] = 6'($urandom_range(0, 63));
      p_data[p] = $urandom;
   endtask

   task automatic set_lat(input int a, input int w,
                          input int b, input int ar,
                          input int r);
      aw_lat = a; w_lat = w; b_lat = b;
      ar_lat = ar; r_lat = r;
   endtask

   task automatic wait_done(output logic [1:0] d,
                            output logic [31:0] rd,
                            output logic [1:0] rs,
                            output bit ok);
      bit pa, pw;
      aw_cyc = 0; w_cyc = 0; aw_rises = 0; w_rises = 0;
      aw_seen = '0; ar_seen = '0; w_seen = '0;
      w_first = 0; bad_order = 0; overlap = 0;
      pa = 0; pw = 0; ok = 0;
      d = '0; rd = '0; rs = '0;
      for (int c = 0; c < 200; c++) begin
         @(negedge clk);
         if (bus.awvalid) begin
            aw_cyc++; aw_seen = bus.awaddr;
            if (!pa) aw_rises++;
         end
         if (bus.wvalid) begin
            w_cyc++; w_seen = bus.wdata;
            if (!pw) w_rises++;
         end
         pa = bus.awvalid;
         pw = bus.wvalid;
         if (bus.arvalid) ar_seen = bus.araddr;
         if (bus.awvalid && !bus.wvalid) w_first = 1;
         if (bus.bready && (bus.awvalid || bus.wvalid))
            bad_order = 1;
         if ((bus.awvalid || bus.wvalid || bus.bready) &&
             (bus.arvalid || bus.rready))
            overlap = 1;
         if (req_done != 2'b00) begin
            d = req_done; rd = req_rdata; rs = req_resp;
            ok = 1;
            break;
         end
      end
   endtask

   task automatic test_reset();
      rst_n = 0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready,
           bus.arvalid, bus.rready} !== 5'b0) begin
         n_fail++;
         $display("FAIL reset_hs: got %b expected 00000",
                  {bus.awvalid, bus.wvalid, bus.bready,
                   bus.arvalid, bus.rready});
      end
      n_checks++;
      if ({bus.awaddr, bus.araddr, bus.wdata} !== 44'h0) begin
         n_fail++;
         $display("FAIL reset_addr: got %h expected 0",
                  {bus.awaddr, bus.araddr, bus.wdata});
      end
      n_checks++;
      if ({req_done, req_resp, req_rdata} !== 36'h0) begin
         n_fail++;
         $display("FAIL reset_req: got %h expected 0",
                  {req_done, req_resp, req_rdata});
      end
      rst_n = 1;
      @(negedge clk);
   endtask

   task automatic test_write_p0();
      logic [1:0] d; logic [31:0] rd; logic [1:0] rs; bit ok;
      set_lat(1, 1, 0, 0, 0);
      p_we[0] = 1; p_addr[0] = 6'h08; p_data[0] = 32'hDEADBEEF;
      p_valid = 2'b01;
      apply_req();
      wait_done(d, rd, rs, ok);
      p_valid = 2'b00;
      apply_req();
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL wr0_timeout: no req_done within bound");
      end
      n_checks++;
      if (d !== 2'b01) begin
         n_fail++;
         $display("FAIL wr0_done: got %b expected 01", d);
      end
      n_checks++;
      if (rs !== 2'b00) begin
         n_fail++;
         $display("FAIL wr0_resp: got %b expected 00", rs);
      end
      n_checks++;
      if (aw_rises !== 1 || w_rises !== 1) begin
         n_fail++;
         $display("FAIL wr0_burst: aw %0d w %0d expected 1 1",
                  aw_rises, w_rises);
      end
      n_checks++;
      if (aw_seen !== 6'h08 || w_seen !== 32'hDEADBEEF) begin
         n_fail++;
         $display("FAIL wr0_bus: got %h/%h expected 08/deadbeef",
                  aw_seen, w_seen);
      end
      n_checks++;
      if (rd !== 32'h0) begin
         n_fail++;
         $display("FAIL wr0_rdata_init: got %h expected 0", rd);
      end
      @(negedge clk);
      n_checks++;
      if (req_done !== 2'b00) begin
         n_fail++;
         $display("FAIL wr0_pulse: got %b expected 00", req_done);
      end
      ref_mem[8] = 32'hDEADBEEF;
      model_last = 0;
   endtask

   task automatic test_read_p1();
      logic [1:0] d; logic [31:0] rd; logic [1:0] rs; bit ok;
      p_we[1] = 0; p_addr[1] = 6'h08; p_data[1] = $urandom;
      p_valid = 2'b10;
      apply_req();
      wait_done(d, rd, rs, ok);
      p_valid = 2'b00;
      apply_req();
      n_checks++;
      if (!ok || d !== 2'b10) begin
         n_fail++;
         $display("FAIL rd1_done: got %b expected 10", d);
      end
      n_checks++;
      if (ar_seen !== 6'h08) begin
         n_fail++;
         $display("FAIL rd1_araddr: got %h expected 08", ar_seen);
      end
      n_checks++;
      if (rd !== 32'hDEADBEEF || rs !== 2'b00) begin
         n_fail++;
         $display("FAIL rd1_data: got %h/%b expected deadbeef/00",
                  rd, rs);
      end
      model_last = 1;
      last_rd = 32'hDEADBEEF;
   endtask

   task automatic run_random(input int n, input bit both,
                             input string tag);
      logic [1:0] d; logic [31:0] rd; logic [1:0] rs; bit ok;
      logic [1:0]  exp_d;
      logic [31:0] exp_rd;
      int exp_p;
      new_txn(0); new_txn(1);
      p_valid = both ? 2'b11 : 2'($urandom_range(1, 3));
      apply_req();
      for (int k = 0; k < n; k++) begin
         exp_p = (p_valid == 2'b11) ? 1 - model_last
                                    : (p_valid[1] ? 1 : 0);
         exp_d = (exp_p == 1) ? 2'b10 : 2'b01;
         wait_done(d, rd, rs, ok);
         n_checks++;
         if (!ok) begin
            n_fail++;
            $display("FAIL %s_timeout: txn %0d", tag, k);
            break;
         end
         n_checks++;
         if (d !== exp_d) begin
            n_fail++;
            $display("FAIL %s_grant: txn %0d got %b expected %b",
                     tag, k, d, exp_d);
         end
         if (p_we[exp_p]) begin
            ref_mem[p_addr[exp_p]] = p_data[exp_p];
            n_checks++;
            if (rs !== p_addr[exp_p][5:4] || rd !== last_rd) begin
               n_fail++;
               $display("FAIL %s_wr: txn %0d got %b/%h expected %b/%h",
                        tag, k, rs, rd, p_addr[exp_p][5:4], last_rd);
            end
         end else begin
            exp_rd = ref_mem[p_addr[exp_p]];
            n_checks++;
            if (rd !== exp_rd || rs !== 2'b00) begin
               n_fail++;
               $display("FAIL %s_rd: txn %0d got %h/%b expected %h/00",
                        tag, k, rd, rs, exp_rd);
            end
            last_rd = exp_rd;
         end
         n_checks++;
         if (overlap || bad_order) begin
            n_fail++;
            $display("FAIL %s_outstanding: txn %0d got %b%b expected 00",
                     tag, k, overlap, bad_order);
         end
         model_last = exp_p;
         if (both) begin
            new_txn(exp_p);
         end else begin
            p_valid[exp_p] = 1'($urandom_range(0, 1));
            if (p_valid[exp_p]) new_txn(exp_p);
            if (!p_valid[1 - exp_p] && $urandom_range(0, 1) == 1) begin
               p_valid[1 - exp_p] = 1'b1;
               new_txn(1 - exp_p);
            end
            if (p_valid == 2'b00) begin
               exp_p = $urandom_range(0, 1);
               p_valid[exp_p] = 1'b1;
               new_txn(exp_p);
            end
         end
         apply_req();
      end
      p_valid = 2'b00;
      apply_req();
      repeat (2) @(negedge clk);
   endtask

   task automatic test_alternate();
      sl_rand = 0;
      set_lat(0, 2, 1, 1, 0);
      run_random(8, 1, "alt");
   endtask

   task automatic test_w_before_aw();
      logic [1:0] d; logic [31:0] rd; logic [1:0] rs; bit ok;
      logic [31:0] data;
      sl_rand = 0;
      set_lat(4, 1, 1, 0, 0);
      data = $urandom;
      p_we[0] = 1; p_addr[0] = 6'h14; p_data[0] = data;
      p_valid = 2'b01;
      apply_req();
      wait_done(d, rd, rs, ok);
      p_valid = 2'b00;
      apply_req();
      n_checks++;
      if (!ok || d !== 2'b01 || rs !== 2'b01) begin
         n_fail++;
         $display("FAIL wfirst_done: got %b/%b expected 01/01", d, rs);
      end
      n_checks++;
      if (w_cyc !== 2 || aw_cyc !== 5) begin
         n_fail++;
         $display("FAIL wfirst_len: w %0d aw %0d expected 2 5",
                  w_cyc, aw_cyc);
      end
      n_checks++;
      if (!w_first || bad_order) begin
         n_fail++;
         $display("FAIL wfirst_order: got %b%b expected 10",
                  w_first, bad_order);
      end
      ref_mem[6'h14] = data;
      model_last = 0;
      p_we[1] = 0; p_addr[1] = 6'h14;
      p_valid = 2'b10;
      apply_req();
      wait_done(d, rd, rs, ok);
      p_valid = 2'b00;
      apply_req();
      n_checks++;
      if (!ok || d !== 2'b10 || rd !== data) begin
         n_fail++;
         $display("FAIL wfirst_readback: got %b/%h expected 10/%h",
                  d, rd, data);
      end
      model_last = 1;
      last_rd = data;
   endtask

   task automatic test_reset_mid();
      logic [1:0] d; logic [31:0] rd; logic [1:0] rs; bit ok;
      bit seen, got_done;
      sl_rand = 0;
      set_lat(0, 0, 6, 1, 1);
      p_we[0] = 1; p_addr[0] = 6'h3C; p_data[0] = ref_mem[6'h3C];
      p_valid = 2'b01;
      apply_req();
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus.bready) begin
            seen = 1;
            break;
         end
      end
      n_checks++;
      if (!seen) begin
         n_fail++;
         $display("FAIL rstmid_wresp: bready not seen within bound");
      end
      p_valid = 2'b00;
      apply_req();
      rst_n = 0;
      #1;
      n_checks++;
      if ({bus.awvalid, bus.wvalid, bus.bready,
           bus.arvalid, bus.rready, req_done} !== 7'b0) begin
         n_fail++;
         $display("FAIL rstmid_hs: got %b expected 0",
                  {bus.awvalid, bus.wvalid, bus.bready,
                   bus.arvalid, bus.rready, req_done});
      end
      n_checks++;
      if ({bus.awaddr, bus.wdata, req_resp, req_rdata} !== 72'h0) begin
         n_fail++;
         $display("FAIL rstmid_data: got %h expected 0",
                  {bus.awaddr, bus.wdata, req_resp, req_rdata});
      end
      repeat (2) @(negedge clk);
      rst_n = 1;
      model_last = 1;
      last_rd = '0;
      got_done = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (req_done !== 2'b00) got_done = 1;
      end
      n_checks++;
      if (got_done) begin
         n_fail++;
         $display("FAIL rstmid_nodone: got 1 expected 0");
      end
      p_we[0] = 0; p_addr[0] = 6'h08;
      p_we[1] = 0; p_addr[1] = 6'h14;
      p_valid = 2'b11;
      apply_req();
      wait_done(d, rd, rs, ok);
      p_valid = 2'b10;
      apply_req();
      n_checks++;
      if (!ok || d !== 2'b01 || rd !== ref_mem[8]) begin
         n_fail++;
         $display("FAIL rstmid_first: got %b/%h expected 01/%h",
                  d, rd, ref_mem[8]);
      end
      wait_done(d, rd, rs, ok);
      p_valid = 2'b00;
      apply_req();
      n_checks++;
      if (!ok || d !== 2'b10 || rd !== ref_mem[6'h14]) begin
         n_fail++;
         $display("FAIL rstmid_second: got %b/%h expected 10/%h",
                  d, rd, ref_mem[6'h14]);
      end
      model_last = 1;
      last_rd = ref_mem[6'h14];
   endtask

   task automatic test_drop_midread();
      logic [1:0] d; logic [31:0] rd; logic [1:0] rs; bit ok;
      bit seen;
      sl_rand = 0;
      set_lat(0, 0, 0, 3, 2);
      p_we[0] = 0; p_addr[0] = 6'h08;
      p_valid = 2'b01;
      apply_req();
      seen = 0;
      for (int c = 0; c < 50; c++) begin
         @(negedge clk);
         if (bus.arvalid) begin
            seen = 1;
            break;
         end
      end
      p_valid = 2'b00;
      p_addr[0] = 6'h10;
      p_we[0] = 1;
      apply_req();
      wait_done(d, rd, rs, ok);
      n_checks++;
      if (!seen || !ok || d !== 2'b01) begin
         n_fail++;
         $display("FAIL drop_done: got %b expected 01", d);
      end
      n_checks++;
      if (ar_seen !== 6'h08 || rd !== ref_mem[8]) begin
         n_fail++;
         $display("FAIL drop_data: got %h/%h expected 08/%h",
                  ar_seen, rd, ref_mem[8]);
      end
      model_last = 0;
      last_rd = ref_mem[8];
      repeat (2) @(negedge clk);
   endtask

   task automatic test_random();
      sl_rand = 1;
      set_lat(2, 0, 1, 3, 1);
      run_random(24, 0, "rnd");
   endtask

   initial begin
      n_checks = 0;
      n_fail = 0;
      rst_n = 0;
      sl_rand = 0;
      set_lat(0, 0, 0, 0, 0);
      model_last = 1;
      last_rd = '0;
      for (int i = 0; i < 64; i++) ref_mem[i] = '0;
      for (int p = 0; p < 2; p++) begin
         p_we[p] = 0; p_addr[p] = '0; p_data[p] = '0;
      end
      p_valid = 2'b00;
      apply_req();
      test_reset();
      test_write_p0();
      test_read_p1();
      test_alternate();
      test_w_before_aw();
      test_reset_mid();
      test_drop_midread();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
